insertion_sort_fifo: RTL and testbench

- Buffered sorter: load a batch of unsigned words, sort them in place with a sequential insertion-sort engine, then read them back in order.
- Commands arrive as toggle-encoded levels (any transition is one command), so they can cross from slow control logic without pulse stretching.
- Sits between a producer/consumer control block and downstream logic needing ordered data.

---
 rtl/insertion_sort_pkg.sv | 33 +++
 rtl/insertion_sort_fifo_if.sv | 30 +++
 rtl/insertion_sort_fifo_toggle_event_det.sv | 20 ++
 rtl/insertion_sort_fifo.sv | 155 +++++++++++++++
 tb/tb_insertion_sort_fifo.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/insertion_sort_pkg.sv
// Shared definitions for the insertion-sort FIFO: sort-engine states,
// default geometry and the same-cycle command priority encoder.
package insertion_sort_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE,
    OUTER,
    INNER,
    INSERT
  } sort_state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_CLEAR,
    CMD_SORT,
    CMD_PUSH,
    CMD_POP
  } cmd_e;

  // Only one command runs per cycle: clear beats sort beats push beats pop.
  function automatic cmd_e encodeCmd(input logic clearEv, input logic sortEv,
                                     input logic pushEv, input logic popEv);
    if (clearEv)     return CMD_CLEAR;
    else if (sortEv) return CMD_SORT;
    else if (pushEv) return CMD_PUSH;
    else if (popEv)  return CMD_POP;
    else             return CMD_NONE;
  endfunction

endpackage

// File: rtl/insertion_sort_fifo_if.sv
// Command/data bundle between the control block (master) and the sorter
// (slave). Commands are toggle-encoded levels.
interface insertion_sort_fifo_if
  import insertion_sort_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             enable;
  logic [WIDTH-1:0] din;
  logic             push;
  logic             pop;
  logic             clear;
  logic             sort;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic             idle;

  modport master (
    output enable, din, push, pop, clear, sort,
    input  dout, full, empty, idle
  );

  modport slave (
    input  enable, din, push, pop, clear, sort,
    output dout, full, empty, idle
  );

endinterface

// File: rtl/insertion_sort_fifo_toggle_event_det.sv
// Toggle-to-event converter: registers a command level once and flags any
// change of that level as a one-cycle event.
module toggle_event_det (
  input  logic clk,
  input  logic rstn,
  input  logic level_i,
  output logic event_o
);

  logic prev_q;

  // Track the previous level unconditionally so stale toggles never linger.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) prev_q <= 1'b0;
    else       prev_q <= level_i;
  end

  assign event_o = level_i ^ prev_q;

endmodule

// File: rtl/insertion_sort_fifo.sv
// Buffered sorter: push words, sort the unread region with a one-compare-
// per-cycle insertion sort, then pop them back in order.
// Build option: define INSERTION_SORT_DESCEND_EN for descending order.
module insertion_sort_fifo
  import insertion_sort_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input logic               clk,
  input logic               rstn,
  insertion_sort_fifo_if.slave bus
);

  localparam logic [AW:0]   IdxOne    = (AW+1)'(1);
  localparam logic [AW:0]   FullCount = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] AddrOne   = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             pushEv, popEv, clearEv, sortEv;
  cmd_e             cmd;
  sort_state_e      state_q, state_d;
  logic [AW:0]      count_q, count_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic [AW:0]      i_q, i_d;
  logic [AW:0]      j_q, j_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             memWe;
  logic [AW-1:0]    memWaddr;
  logic [WIDTH-1:0] memWdata;
  logic [WIDTH-1:0] prevWord;
  logic             shiftNeeded;
  logic             fullS, emptyS;

  toggle_event_det uPushDet  (.clk(clk), .rstn(rstn), .level_i(bus.push),  .event_o(pushEv));
  toggle_event_det uPopDet   (.clk(clk), .rstn(rstn), .level_i(bus.pop),   .event_o(popEv));
  toggle_event_det uClearDet (.clk(clk), .rstn(rstn), .level_i(bus.clear), .event_o(clearEv));
  toggle_event_det uSortDet  (.clk(clk), .rstn(rstn), .level_i(bus.sort),  .event_o(sortEv));

  assign cmd      = encodeCmd(clearEv, sortEv, pushEv, popEv);
  assign fullS    = (count_q == FullCount);
  assign emptyS   = (rdPtr_q == count_q);
  assign prevWord = mem[j_q[AW-1:0] - AddrOne];

`ifdef INSERTION_SORT_DESCEND_EN
  assign shiftNeeded = (j_q > rdPtr_q) && (prevWord < key_q);
`else
  assign shiftNeeded = (j_q > rdPtr_q) && (prevWord > key_q);
`endif

  // Command execution in IDLE and the insertion-sort walk; everything freezes while enable is low.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rdPtr_d  = rdPtr_q;
    i_d      = i_q;
    j_d      = j_q;
    key_d    = key_q;
    dout_d   = dout_q;
    memWe    = 1'b0;
    memWaddr = count_q[AW-1:0];
    memWdata = bus.din;
    if (bus.enable) begin
      unique case (state_q)
        IDLE: begin
          unique case (cmd)
            CMD_CLEAR: begin
              count_d = '0;
              rdPtr_d = '0;
            end
            CMD_SORT: begin
              i_d     = rdPtr_q + IdxOne;
              state_d = OUTER;
            end
            CMD_PUSH: begin
              if (!fullS) begin
                memWe   = 1'b1;
                count_d = count_q + IdxOne;
              end
            end
            CMD_POP: begin
              if (!emptyS) begin
                dout_d  = mem[rdPtr_q[AW-1:0]];
                rdPtr_d = rdPtr_q + IdxOne;
              end
            end
            default: ;
          endcase
        end
        OUTER: begin
          if (i_q >= count_q) begin
            state_d = IDLE;
          end else begin
            key_d   = mem[i_q[AW-1:0]];
            j_d     = i_q;
            state_d = INNER;
          end
        end
        INNER: begin
          if (shiftNeeded) begin
            memWe    = 1'b1;
            memWaddr = j_q[AW-1:0];
            memWdata = prevWord;
            j_d      = j_q - IdxOne;
          end else begin
            state_d = INSERT;
          end
        end
        INSERT: begin
          memWe    = 1'b1;
          memWaddr = j_q[AW-1:0];
          memWdata = key_q;
          i_d      = i_q + IdxOne;
          state_d  = OUTER;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state; reset abandons any sort in flight and empties the buffer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      count_q <= '0;
      rdPtr_q <= '0;
      i_q     <= '0;
      j_q     <= '0;
      key_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rdPtr_q <= rdPtr_d;
      i_q     <= i_d;
      j_q     <= j_d;
      key_q   <= key_d;
      dout_q  <= dout_d;
    end
  end

  // Storage array has no reset; its single write port serves push, shift and insert.
  always_ff @(posedge clk) begin
    if (memWe) mem[memWaddr] <= memWdata;
  end

  assign bus.dout  = dout_q;
  assign bus.full  = fullS;
  assign bus.empty = emptyS;
  assign bus.idle  = (state_q == IDLE);

endmodule

// File: tb/tb_insertion_sort_fifo.sv
// Randomized bench for insertion_sort_fifo against a queue-based model.
module tb_insertion_sort_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 256;
  localparam int SORT_BUDGET = 70000;

  logic clk = 1'b0;
  logic rstn;

  insertion_sort_fifo_if #(.WIDTH(WIDTH)) bus ();

  insertion_sort_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  int mdl[$];
  int rdM = 0;
  int expDout = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mdl.delete();
    rdM = 0;
    expDout = 0;
  endtask

  // Sort the unread part of the model queue with the language's own sort.
  task automatic modelSort();
    int tmp[$];
    for (int k = rdM; k < mdl.size(); k++) tmp.push_back(mdl[k]);
`ifdef INSERTION_SORT_DESCEND_EN
    tmp.rsort();
`else
    tmp.sort();
`endif
    for (int k = 0; k < tmp.size(); k++) mdl[rdM + k] = tmp[k];
  endtask

  task automatic pushWord(input int v);
    @(negedge clk);
    bus.din  = WIDTH'(v);
    bus.push = ~bus.push;
    @(negedge clk);
    if (mdl.size() < DEPTH) mdl.push_back(v);
  endtask

  task automatic popWord(input string tag);
    @(negedge clk);
    bus.pop = ~bus.pop;
    @(negedge clk);
    if (rdM < mdl.size()) begin
      expDout = mdl[rdM];
      rdM++;
    end
    checkOutput(tag, int'(bus.dout), expDout);
  endtask

  task automatic clearBuf();
    @(negedge clk);
    bus.clear = ~bus.clear;
    @(negedge clk);
    mdl.delete();
    rdM = 0;
    checkOutput("clear_empty", int'(bus.empty), 1);
  endtask

  task automatic startSort();
    @(negedge clk);
    bus.sort = ~bus.sort;
    @(negedge clk);
    checkOutput("idle_drop", int'(bus.idle), 0);
    modelSort();
  endtask

  task automatic waitIdle(input string tag);
    int k = 0;
    while (!bus.idle && k < SORT_BUDGET) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, int'(bus.idle), 1);
  endtask

  // Push a random batch, sort it and drain it, checking each popped word.
  task automatic applyStimulus(input int n, input int maxVal, input string tag);
    int popped = 0;
    for (int k = 0; k < n; k++) pushWord(int'($urandom_range(0, maxVal)));
    startSort();
    waitIdle({tag, "_done"});
    while (!bus.empty && popped < DEPTH + 4) begin
      popWord(tag);
      popped++;
    end
    checkOutput({tag, "_count"}, popped, mdl.size());
    checkOutput({tag, "_empty"}, int'(bus.empty), 1);
  endtask

  initial begin
    int lastDout;
    int k;
    bus.enable = 1'b1;
    bus.din    = '0;
    bus.push   = 1'b0;
    bus.pop    = 1'b0;
    bus.clear  = 1'b0;
    bus.sort   = 1'b0;
    rstn       = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Reset state
    checkOutput("rst_empty", int'(bus.empty), 1);
    checkOutput("rst_full",  int'(bus.full),  0);
    checkOutput("rst_idle",  int'(bus.idle),  1);
    checkOutput("rst_dout",  int'(bus.dout),  0);
    popWord("rst_pop");

    // Basic sort with a duplicate and a zero
    pushWord(30000); pushWord(5); pushWord(17); pushWord(5); pushWord(0);
    startSort();
    waitIdle("basic_done");
    for (int n = 0; n < 5; n++) popWord("basic_pop");
    checkOutput("basic_empty", int'(bus.empty), 1);
    popWord("basic_extra_pop");

    // Capacity: fill, overfill, sort, drain
    clearBuf();
    for (int n = 0; n < DEPTH; n++) pushWord(int'($urandom_range(0, 65535)));
    checkOutput("cap_full", int'(bus.full), 1);
    pushWord(int'($urandom_range(0, 65535)));
    checkOutput("cap_full_after_extra", int'(bus.full), 1);
    startSort();
    waitIdle("cap_done");
    for (int n = 0; n < DEPTH; n++) popWord("cap_pop");
    checkOutput("cap_empty", int'(bus.empty), 1);

    // Random batches
    for (int r = 0; r < 3; r++) begin
      clearBuf();
      applyStimulus(int'($urandom_range(100, 180)), 32768, "batch");
    end

    // Commands while the engine is busy, then an enable stall
    clearBuf();
    for (int n = 0; n < 100; n++) pushWord(int'($urandom_range(0, 65535)));
    startSort();
    lastDout = int'(bus.dout);
    @(negedge clk);
    bus.din  = WIDTH'($urandom_range(0, 65535));
    bus.push = ~bus.push;
    @(negedge clk);
    bus.pop = ~bus.pop;
    @(negedge clk);
    checkOutput("busy_idle", int'(bus.idle), 0);
    checkOutput("busy_dout", int'(bus.dout), lastDout);
    checkOutput("busy_empty", int'(bus.empty), 0);
    bus.enable = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("stall_idle", int'(bus.idle), 0);
    bus.enable = 1'b1;
    waitIdle("stall_done");
    for (int n = 0; n < 100; n++) popWord("busy_pop");
    checkOutput("busy_drained", int'(bus.empty), 1);

    // Asynchronous reset while the inner loop is shifting
    clearBuf();
    for (int n = 60; n > 0; n--) pushWord(n);
    startSort();
    k = 0;
    while (dut.state_q != insertion_sort_pkg::INNER && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("reach_inner", (k < 100) ? 1 : 0, 1);
    #2;
    rstn      = 1'b0;
    bus.push  = 1'b0;
    bus.pop   = 1'b0;
    bus.clear = 1'b0;
    bus.sort  = 1'b0;
    #1;
    checkOutput("midrst_idle",  int'(bus.idle),  1);
    checkOutput("midrst_empty", int'(bus.empty), 1);
    checkOutput("midrst_dout",  int'(bus.dout),  0);
    modelReset();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    pushWord(3);
    pushWord(1);
    startSort();
    waitIdle("post_rst_done");
    popWord("post_rst_pop");
    popWord("post_rst_pop");
    checkOutput("post_rst_empty", int'(bus.empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
